// File: rtl/data_memory_ctl.sv
// ============================================================================
// Module   : data_memory_ctl
// Brief    : Multi-cycle data memory controller for a single-cycle core.
//            Internal word RAM with a fixed number of wait states. A stall
//            freezes the core until each access completes, done pulses on
//            completion and fault flags misaligned word accesses.
//            Optional byte loads/stores: define DATA_MEMORY_BYTE_ACCESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_ctl #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_write,
`ifdef DATA_MEMORY_BYTE_ACCESS_EN
  input  logic        byte_access,
`endif
  input  logic [31:0] data_memory_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        fault
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;

  // Request captured in IDLE and replayed when the access takes effect
  logic [ADDR_W-1:0] lat_idx;
  logic [1:0]        lat_lane;
  logic [31:0]       lat_data;
  logic              lat_write;
  logic              lat_byte;

  logic [31:0]       mem [DEPTH_WORDS];

  logic              req_byte;
  logic [ADDR_W-1:0] req_idx;
  logic [1:0]        req_lane;
  logic              req_misaligned;
  logic              unused_addr_bits;

`ifdef DATA_MEMORY_BYTE_ACCESS_EN
  assign req_byte = byte_access;
`else
  assign req_byte = 1'b0;
`endif

  // Upper address bits are deliberately ignored so addresses wrap
  assign req_idx          = data_memory_addr[ADDR_W+1:2];
  assign req_lane         = data_memory_addr[1:0];
  assign req_misaligned   = (req_lane != 2'b00) && !req_byte;
  assign unused_addr_bits = ^data_memory_addr[31:ADDR_W+2];

  // Access currently taking effect: live inputs for a zero-wait access from
  // IDLE, latched values on the last BUSY cycle
  logic [ADDR_W-1:0] acc_idx;
  logic [1:0]        acc_lane;
  logic [31:0]       acc_data;
  logic              acc_write;
  logic              acc_byte;
  logic              acc_fire;

  // Select the source of the access that completes on the coming edge
  always_comb begin
    acc_idx   = lat_idx;
    acc_lane  = lat_lane;
    acc_data  = lat_data;
    acc_write = lat_write;
    acc_byte  = lat_byte;
    acc_fire  = 1'b0;
    if (state == IDLE) begin
      acc_idx   = req_idx;
      acc_lane  = req_lane;
      acc_data  = write_data;
      acc_write = mem_write;
      acc_byte  = req_byte;
      acc_fire  = mem_req && !req_misaligned && (WAIT_STATES == 0);
    end else if (state == BUSY) begin
      acc_fire  = (counter == '0);
    end
  end

  logic [31:0] old_word;
  logic [7:0]  lane_byte;
  logic [31:0] load_value;
  logic [31:0] store_word;
  logic        ram_we;

  assign old_word   = mem[acc_idx];
  assign lane_byte  = old_word[{acc_lane, 3'b000} +: 8];
  assign load_value = acc_byte ? {24'h000000, lane_byte} : old_word;
  // An abort by reset must not leave a half-finished store behind
  assign ram_we     = acc_fire && acc_write && !reset;

  // Merge a byte store into the existing word; word stores replace it
  always_comb begin
    store_word = acc_data;
    if (acc_byte) begin
      store_word = old_word;
      store_word[{acc_lane, 3'b000} +: 8] = acc_data[7:0];
    end
  end

  // RAM write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[acc_idx] <= store_word;
    end
  end

  // Access sequencer with registered done/fault/read_data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      read_data <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
      lat_idx   <= '0;
      lat_lane  <= '0;
      lat_data  <= '0;
      lat_write <= 1'b0;
      lat_byte  <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            lat_idx   <= req_idx;
            lat_lane  <= req_lane;
            lat_data  <= write_data;
            lat_write <= mem_write;
            lat_byte  <= req_byte;
            if (req_misaligned) begin
              state     <= DONE;
              done      <= 1'b1;
              fault     <= 1'b1;
              read_data <= '0;
            end else if (WAIT_STATES == 0) begin
              state <= DONE;
              done  <= 1'b1;
              if (!mem_write) begin
                read_data <= load_value;
              end
            end else begin
              state   <= BUSY;
              counter <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (counter == '0) begin
            state <= DONE;
            done  <= 1'b1;
            if (!lat_write) begin
              read_data <= load_value;
            end
          end else begin
            counter <= counter - CNT_W'(1);
          end
        end
        DONE: begin
          // mem_req here still belongs to the completing instruction
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stall the core from the first request cycle until DONE
  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    stall = mem_req;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ctl.sv
// ============================================================================
// Module   : tb_data_memory_ctl
// Brief    : Self-checking bench for data_memory_ctl. A transaction-level
//            model (word array plus per-access latency schedule) predicts
//            stall/done/fault/read_data every cycle; a second instance with
//            zero wait states gets a few directed accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_ctl;

  localparam int DEPTH = 64;
  localparam int WS    = 2;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        mem_req = 1'b0, mem_write = 1'b0, byte_acc = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rd;
  logic        stall, done, fault;

  logic        z_req = 1'b0, z_wr = 1'b0;
  logic [31:0] z_addr = '0, z_wdata = '0;
  logic [31:0] z_rd;
  logic        z_stall, z_done, z_fault;

  data_memory_ctl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_write(mem_write),
`ifdef DATA_MEMORY_BYTE_ACCESS_EN
    .byte_access(byte_acc),
`endif
    .data_memory_addr(addr), .write_data(wdata), .read_data(rd),
    .stall(stall), .done(done), .fault(fault)
  );

  data_memory_ctl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dz (
    .clk(clk), .reset(reset), .mem_req(z_req), .mem_write(z_wr),
`ifdef DATA_MEMORY_BYTE_ACCESS_EN
    .byte_access(1'b0),
`endif
    .data_memory_addr(z_addr), .write_data(z_wdata), .read_data(z_rd),
    .stall(z_stall), .done(z_done), .fault(z_fault)
  );

  // Reference model state
  logic [31:0] mm [DEPTH];
  logic        exp_stall = 1'b0, exp_done = 1'b0, exp_fault = 1'b0;
  logic [31:0] exp_rd = '0;

  int n_cmp = 0, n_bad = 0;
  int cyc_n = 0, done_cyc = -1, stall_cnt = 0;
  bit fault_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc_n++;

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    check("stall", 32'(stall), 32'(exp_stall));
    check("done", 32'(done), 32'(exp_done));
    check("fault", 32'(fault), 32'(exp_fault));
    check("read_data", rd, exp_rd);
    if (done) done_cyc = cyc_n;
    if (stall) stall_cnt++;
    if (fault) fault_seen = 1'b1;
  end

  // One access on the main DUT; the core holds mem_req while stalled and
  // the other inputs wander to show they are not re-sampled
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input bit by, output int lat);
    bit          be, mis;
    int          len, idx, lane, start;
    logic [31:0] rd_after;
`ifdef DATA_MEMORY_BYTE_ACCESS_EN
    be = by;
`else
    be = 1'b0 & by;
`endif
    idx   = int'(a[AW+1:2]);
    lane  = int'(a[1:0]);
    mis   = (lane != 0) && !be;
    len   = mis ? 1 : WS + 1;
    start = cyc_n;
    stall_cnt  = 0;
    fault_seen = 1'b0;
    done_cyc   = -1;
    mem_req = 1'b1; mem_write = wr; addr = a; wdata = d; byte_acc = be;
    exp_stall = 1'b1; exp_done = 1'b0; exp_fault = 1'b0;
    for (int k = 1; k < len; k++) begin
      cyc();
      mem_write = 1'($urandom); addr = $urandom; wdata = $urandom; byte_acc = 1'($urandom);
    end
    cyc();
    if (mis) begin
      rd_after = '0;
    end else if (wr) begin
      if (be) mm[idx][8*lane +: 8] = d[7:0];
      else    mm[idx] = d;
      rd_after = exp_rd;
    end else begin
      rd_after = be ? {24'h0, mm[idx][8*lane +: 8]} : mm[idx];
    end
    exp_stall = 1'b0; exp_done = 1'b1; exp_fault = mis; exp_rd = rd_after;
    mem_req = 1'($urandom); mem_write = 1'($urandom); addr = $urandom; wdata = $urandom;
    cyc();
    mem_req = 1'b0;
    exp_done = 1'b0; exp_fault = 1'b0;
    lat = done_cyc - start;
  endtask

  // Directed access on the zero-wait-state instance
  task automatic z_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_r, input bit exp_f);
    z_req = 1'b1; z_wr = wr; z_addr = a; z_wdata = d;
    @(negedge clk);
    check("z_stall_c0", 32'(z_stall), 32'd1);
    check("z_done_c0", 32'(z_done), 32'd0);
    cyc();
    z_req = 1'b0; z_addr = $urandom;
    @(negedge clk);
    check("z_stall_c1", 32'(z_stall), 32'd0);
    check("z_done_c1", 32'(z_done), 32'd1);
    check("z_fault_c1", 32'(z_fault), 32'(exp_f));
    check("z_read_data", z_rd, exp_r);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    // Reset: stall forced low even with a request pending
    reset = 1'b1;
    mem_req = 1'b1;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    repeat (3) cyc();
    mem_req = 1'b0;
    reset = 1'b0;
    cyc();

    // Give every RAM word a known value
    for (int i = 0; i < DEPTH; i++) do_access(1'b1, 32'(i * 4), $urandom, 1'b0, lat);

    // Store then load at 0x20
    do_access(1'b1, 32'h20, 32'h0000000F, 1'b0, lat);
    check("st20_latency", 32'(lat), 32'd3);
    check("st20_stall_cycles", 32'(stall_cnt), 32'd3);
    do_access(1'b0, 32'h20, 32'h0, 1'b0, lat);
    check("ld20_data", rd, 32'h0000000F);
    check("ld20_latency", 32'(lat), 32'd3);
    check("ld20_stall_cycles", 32'(stall_cnt), 32'd3);

    // Misaligned load and store
    do_access(1'b0, 32'h22, 32'h0, 1'b0, lat);
    check("mis_ld_data", rd, 32'h0);
    check("mis_ld_fault", 32'(fault_seen), 32'd1);
    check("mis_ld_latency", 32'(lat), 32'd1);
    do_access(1'b1, 32'h21, 32'hFFFFFFFF, 1'b0, lat);
    do_access(1'b0, 32'h20, 32'h0, 1'b0, lat);
    check("after_mis_ld20", rd, 32'h0000000F);

    // Address wrap
    do_access(1'b1, 32'h100, 32'hA5A5A5A5, 1'b0, lat);
    do_access(1'b0, 32'h000, 32'h0, 1'b0, lat);
    check("wrap_ld0", rd, 32'hA5A5A5A5);

    // Reset during BUSY aborts the store
    do_access(1'b1, 32'h40, 32'h0BADF00D, 1'b0, lat);
    mem_req = 1'b1; mem_write = 1'b1; addr = 32'h40; wdata = 32'h12345678;
    exp_stall = 1'b1;
    cyc();
    reset = 1'b1;
    exp_stall = 1'b0; exp_rd = '0;
    #1;
    check("rst_busy_stall", 32'(stall), 32'd0);
    cyc();
    reset = 1'b0; mem_req = 1'b0;
    cyc();
    do_access(1'b0, 32'h40, 32'h0, 1'b0, lat);
    check("rst_abort_ld40", rd, 32'h0BADF00D);

`ifdef DATA_MEMORY_BYTE_ACCESS_EN
    do_access(1'b1, 32'h10, 32'h11223344, 1'b0, lat);
    do_access(1'b1, 32'h11, 32'h000000FF, 1'b1, lat);
    check("byte_st_fault", 32'(fault_seen), 32'd0);
    do_access(1'b0, 32'h10, 32'h0, 1'b0, lat);
    check("byte_st_word", rd, 32'h1122FF44);
    do_access(1'b0, 32'h13, 32'h0, 1'b1, lat);
    check("byte_ld13", rd, 32'h00000011);
`endif

    // Zero wait states
    z_access(1'b1, 32'h04, 32'hDEADBEEF, 32'h0, 1'b0);
    z_access(1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0);
    z_access(1'b0, 32'h06, 32'h0, 32'h0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        addr = $urandom; wdata = $urandom;
        cyc();
      end
      a = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_access(1'($urandom), a, $urandom, ($urandom_range(0, 2) == 0), lat);
    end

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
